// File: rtl/gray_encoder_decoder.sv
// gray_encoder_decoder: registered binary/Gray codec with a self-checking round-trip path
module gray_encoder_decoder #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enc_valid_in,
   input  logic [WIDTH-1:0] in_binary,
   input  logic             dec_valid_in,
   input  logic [WIDTH-1:0] in_gray,
   output logic             gray_valid,
   output logic [WIDTH-1:0] out_gray,
   output logic             bin_valid,
   output logic [WIDTH-1:0] out_binary,
   output logic             rt_valid,
   output logic [WIDTH-1:0] rt_binary,
   output logic             rt_error
);
   logic [WIDTH-1:0] binDelayed;
   logic [WIDTH-1:0] rtNext;

   function automatic logic [WIDTH-1:0] toGray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [WIDTH-1:0] toBinary(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   always_comb rtNext = toBinary(out_gray);

   always_ff @(posedge clk) begin
      if (rst) begin
         gray_valid <= 1'b0;
         out_gray   <= '0;
         binDelayed <= '0;
         bin_valid  <= 1'b0;
         out_binary <= '0;
         rt_valid   <= 1'b0;
         rt_binary  <= '0;
         rt_error   <= 1'b0;
      end else begin
         gray_valid <= enc_valid_in;
         bin_valid  <= dec_valid_in;
         rt_valid   <= gray_valid;
         if (enc_valid_in) begin
            out_gray   <= toGray(in_binary);
            binDelayed <= in_binary;
         end
         if (dec_valid_in) out_binary <= toBinary(in_gray);
         if (gray_valid) begin
            rt_binary <= rtNext;
            rt_error  <= rtNext != binDelayed;
         end
      end
   end
endmodule

// File: tb/tb_gray_encoder_decoder.sv
// tb_gray_encoder_decoder: directed and random checks of gray_encoder_decoder against a search-based model
module tb_gray_encoder_decoder;
   localparam int W = 6;
   logic clk = 0, rst = 0, enc_valid_in = 0, dec_valid_in = 0;
   logic [W-1:0] in_binary = '0, in_gray = '0;
   logic gray_valid, bin_valid, rt_valid, rt_error;
   logic [W-1:0] out_gray, out_binary, rt_binary;
   int total = 0, bad = 0;
   logic expGv = 0, expBv = 0, expRv = 0, expErr = 0;
   logic [W-1:0] expGray = '0, expBin = '0, expRt = '0, pendBin = '0, prevGray;

   gray_encoder_decoder #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .enc_valid_in(enc_valid_in), .in_binary(in_binary),
      .dec_valid_in(dec_valid_in), .in_gray(in_gray), .gray_valid(gray_valid),
      .out_gray(out_gray), .bin_valid(bin_valid), .out_binary(out_binary),
      .rt_valid(rt_valid), .rt_binary(rt_binary), .rt_error(rt_error)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] mEnc(input int b);
      return W'(b ^ (b >> 1));
   endfunction

   // the binary word whose Gray code equals g, found by search
   function automatic logic [W-1:0] mDec(input logic [W-1:0] g);
      logic [W-1:0] r = '0;
      for (int v = 0; v < (1 << W); v++) if (mEnc(v) == g) r = W'(v);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic [W-1:0] b, input logic d, input logic [W-1:0] g);
      rst = r; enc_valid_in = e; in_binary = b; dec_valid_in = d; in_gray = g;
      @(posedge clk);
      #1;
      if (r) begin
         {expGv, expBv, expRv, expErr} = '0;
         {expGray, expBin, expRt, pendBin} = '0;
      end else begin
         expRv = expGv;
         if (expGv) begin
            expRt = pendBin;
            expErr = 1'b0;
         end
         expGv = e;
         if (e) begin
            expGray = mEnc(int'(b));
            pendBin = b;
         end
         expBv = d;
         if (d) expBin = mDec(g);
      end
      chk("gray_valid", 32'(gray_valid), 32'(expGv));
      chk("out_gray", 32'(out_gray), 32'(expGray));
      chk("bin_valid", 32'(bin_valid), 32'(expBv));
      chk("out_binary", 32'(out_binary), 32'(expBin));
      chk("rt_valid", 32'(rt_valid), 32'(expRv));
      chk("rt_binary", 32'(rt_binary), 32'(expRt));
      chk("rt_error", 32'(rt_error), 32'(expErr));
   endtask

   initial begin
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 1, 6'b100101, 0, 0);
      chk("dir_gray", 32'(out_gray), 32'(6'b110111));
      step(0, 0, 0, 0, 0);
      chk("dir_rt", 32'(rt_binary), 32'(6'b100101));
      chk("dir_rtv", 32'(rt_valid), 1);
      step(0, 0, 0, 1, 6'b000000);
      chk("dec0", 32'(out_binary), 32'(6'b000000));
      step(0, 0, 0, 1, 6'b000011);
      chk("dec3", 32'(out_binary), 32'(6'b000010));
      step(0, 0, 0, 1, 6'b100000);
      chk("dec32", 32'(out_binary), 32'(6'b111111));
      step(0, 0, 0, 1, 6'b110111);
      chk("dec55", 32'(out_binary), 32'(6'b100101));
      step(0, 1, 0, 0, 0);
      prevGray = out_gray;
      for (int b = 1; b <= (1 << W); b++) begin
         step(0, 1, W'(b), 0, 0);
         chk("one_bit", 32'($countones(out_gray ^ prevGray)), 1);
         prevGray = out_gray;
      end
      chk("wrap_zero", 32'(out_gray), 0);
      step(0, 1, 6'd63, 0, 0);
      chk("max_gray", 32'(out_gray), 32'(6'b100000));
      step(0, 1, 6'd5, 0, 0);
      step(0, 0, 6'd9, 0, 0);
      step(0, 0, 6'd17, 0, 0);
      step(0, 1, 6'd40, 0, 0);
      step(0, 0, 6'd41, 0, 0);
      step(0, 1, 6'b000001, 1, 6'b111111);
      chk("conc_gray", 32'(out_gray), 32'(6'b000001));
      chk("conc_bin", 32'(out_binary), 32'(6'b101010));
      for (int k = 0; k < 40; k++)
         step(0, 1'($urandom), W'($urandom), 1'($urandom), W'($urandom));
      step(0, 1, 6'd12, 1, 6'd7);
      step(1, 1, 6'd13, 1, 6'd8);
      step(1, 1, 6'd14, 1, 6'd9);
      step(0, 0, 0, 0, 0);
      chk("no_stale_rt", 32'(rt_valid), 0);
      step(0, 0, 0, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
